// File: rtl/cla_byte_serial_adder.sv
// Byte-serial sequencer that feeds an external 8-bit CLA one slice per clock,
// LSB first, chaining the inter-byte carry through a register.
module cla_byte_serial_adder #(
   parameter int NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [8*NBYTES-1:0]   op_a,
   input  logic [8*NBYTES-1:0]   op_b,
   input  logic                  cin,
   output logic                  busy,
   output logic                  done,
   output logic [8*NBYTES-1:0]   sum,
   output logic                  cout,
   output logic [7:0]            add_a,
   output logic [7:0]            add_b,
   output logic                  add_cin,
   input  logic [7:0]            add_s,
   input  logic                  add_cout
);

   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                      state_r;
   logic [NBYTES-1:0][7:0]      a_r;
   logic [NBYTES-1:0][7:0]      b_r;
   logic [NBYTES-1:0][7:0]      sum_r;
   logic [IW-1:0]               idx_r;
   logic                        carry_r;
   logic                        cout_r;
   logic                        busy_r;
   logic                        done_r;

   logic [7:0]                  add_a_s;
   logic [7:0]                  add_b_s;
   logic                        add_cin_s;

   // Sequencer: operand latch, per-byte result capture and carry chaining.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         a_r     <= '0;
         b_r     <= '0;
         sum_r   <= '0;
         idx_r   <= '0;
         carry_r <= 1'b0;
         cout_r  <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         case (state_r)
            // DONE accepts a new start exactly like IDLE, giving back-to-back ops.
            ST_IDLE, ST_DONE: begin
               done_r <= 1'b0;
               if (start) begin
                  a_r     <= op_a;
                  b_r     <= op_b;
                  carry_r <= cin;
                  idx_r   <= '0;
                  busy_r  <= 1'b1;
                  state_r <= ST_RUN;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end
            end
            ST_RUN: begin
               sum_r[idx_r] <= add_s;
               carry_r      <= add_cout;
               if (idx_r == LAST_IDX) begin
                  cout_r  <= add_cout;
                  idx_r   <= '0;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= ST_DONE;
               end else begin
                  idx_r   <= idx_r + IDX_ONE;
                  busy_r  <= 1'b1;
                  done_r  <= 1'b0;
                  state_r <= ST_RUN;
               end
            end
            default: begin
               idx_r   <= '0;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Adder drive comes only from registers so the CLA path is reg -> CLA -> reg.
   always_comb begin
      add_a_s   = 8'h00;
      add_b_s   = 8'h00;
      add_cin_s = 1'b0;
      if (state_r == ST_RUN) begin
         add_a_s   = a_r[idx_r];
         add_b_s   = b_r[idx_r];
         add_cin_s = carry_r;
      end else begin
         add_a_s   = 8'h00;
         add_b_s   = 8'h00;
         add_cin_s = 1'b0;
      end
   end

   assign add_a   = add_a_s;
   assign add_b   = add_b_s;
   assign add_cin = add_cin_s;
   assign busy    = busy_r;
   assign done    = done_r;
   assign sum     = sum_r;
   assign cout    = cout_r;

endmodule
